// File: rtl/erx_align_ctrl.sv
// Frame-alignment controller for the eLink RX deserializer: issues bitslip pulses
// until the training pattern is seen MATCH_CNT times in a row, then reports lock.
//
// state  | meaning
// IDLE   | waiting for align_start
// SETTLE | discarding the first SETTLE_BYTES strobes after align_start
// CHECK  | comparing each strobed byte against TRAIN_PATTERN
// SLIP   | one-cycle bitslip request
// WAIT   | discarding SLIP_WAIT strobes while the deserializer shifts
// LOCKED | alignment achieved
// FAIL   | slips exhausted or strobes stopped arriving
module erx_align_ctrl #(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
   parameter int unsigned MATCH_CNT     = 4,
   parameter int unsigned SETTLE_BYTES  = 2,
   parameter int unsigned SLIP_WAIT     = 3,
   parameter int unsigned MAX_SLIPS     = 8,
   parameter int unsigned TIMEOUT       = 256
) (
   input  logic       rxi_lclk,
   input  logic       reset,
   input  logic       align_start,
   input  logic       byte_valid,
   input  logic [7:0] frame_byte,
   output logic       bitslip,
   output logic       busy,
   output logic       aligned,
   output logic       align_fail,
   output logic       fail_timeout,
   output logic [3:0] slip_cnt
);

   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;

   localparam logic [3:0]  SETTLE_N = 4'(SETTLE_BYTES);
   localparam logic [3:0]  WAIT_N   = 4'(SLIP_WAIT);
   localparam logic [3:0]  MATCH_N  = 4'(MATCH_CNT);
   localparam logic [3:0]  MAX_N    = 4'(MAX_SLIPS);
   localparam logic [15:0] TMO_INIT = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [3:0]  strb_cnt, strb_cnt_n;
   logic [3:0]  match_cnt, match_cnt_n;
   logic [3:0]  slip_cnt_n;
   logic [15:0] tmo_cnt;
   logic        counting, tmo_hit, fail_tmo_n;

   // Timeout is a down-counter reloaded on every strobe and state change; it
   // expires on the TIMEOUT-th consecutive strobe-less cycle in a counting state.
   assign counting = (state == SETTLE) || (state == CHECK) || (state == WAIT);
   assign tmo_hit  = counting && !byte_valid && (tmo_cnt == 16'd0);

   always_comb begin
      state_n     = state;
      strb_cnt_n  = strb_cnt;
      match_cnt_n = match_cnt;
      slip_cnt_n  = slip_cnt;
      fail_tmo_n  = fail_timeout;
      if (align_start) begin
         state_n     = (SETTLE_N == 4'd0) ? CHECK : SETTLE;
         strb_cnt_n  = SETTLE_N;
         match_cnt_n = 4'd0;
         slip_cnt_n  = 4'd0;
         fail_tmo_n  = 1'b0;
      end else if (tmo_hit) begin
         state_n    = FAIL;
         fail_tmo_n = 1'b1;
      end else begin
         case (state)
            SETTLE, WAIT: begin
               if (byte_valid) begin
                  if (strb_cnt <= 4'd1) state_n = CHECK;
                  else                  strb_cnt_n = strb_cnt - 4'd1;
               end
            end
            CHECK: begin
               if (byte_valid) begin
                  if (frame_byte == TRAIN_PATTERN) begin
                     match_cnt_n = match_cnt + 4'd1;
                     if (match_cnt == MATCH_N - 4'd1) state_n = LOCKED;
                  end else if (slip_cnt < MAX_N) begin
                     match_cnt_n = 4'd0;
                     slip_cnt_n  = (slip_cnt == 4'hF) ? 4'hF : slip_cnt + 4'd1;
                     state_n     = SLIP;
                  end else begin
                     state_n = FAIL;
                  end
               end
            end
            SLIP: begin
               strb_cnt_n = WAIT_N;
               state_n    = (WAIT_N == 4'd0) ? CHECK : WAIT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge rxi_lclk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         strb_cnt     <= 4'd0;
         match_cnt    <= 4'd0;
         slip_cnt     <= 4'd0;
         tmo_cnt      <= 16'd0;
         bitslip      <= 1'b0;
         busy         <= 1'b0;
         aligned      <= 1'b0;
         align_fail   <= 1'b0;
         fail_timeout <= 1'b0;
      end else begin
         state     <= state_n;
         strb_cnt  <= strb_cnt_n;
         match_cnt <= match_cnt_n;
         slip_cnt  <= slip_cnt_n;
         if (align_start || byte_valid || (state_n != state)) tmo_cnt <= TMO_INIT;
         else if (counting)                                   tmo_cnt <= tmo_cnt - 16'd1;
         bitslip      <= (state_n == SLIP);
         busy         <= (state_n == SETTLE) || (state_n == CHECK) ||
                         (state_n == SLIP)   || (state_n == WAIT);
         aligned      <= (state_n == LOCKED);
         align_fail   <= (state_n == FAIL);
         fail_timeout <= fail_tmo_n;
      end
   end

endmodule

// File: doc/erx_align_ctrl.md
Name: erx_align_ctrl

Overview:
Frame-alignment controller for the eLink receive deserializer. It watches the deserialized frame lane (8 bits per slow cycle) in the rxi_lclk domain during link training. It issues single-cycle bitslip pulses until the trained pattern is received at the correct bit position, then declares lock. It sits between the RX IO deserializer, which consumes bitslip, and link bring-up logic, which drives align_start and reads the status outputs.

Parameters:
TRAIN_PATTERN, 8'hF0, expected frame-lane byte during training; all 8 rotations are distinct.
MATCH_CNT, 4, consecutive matching bytes required to declare lock (1..15).
SETTLE_BYTES, 2, byte strobes discarded after align_start before the first compare (0..15).
SLIP_WAIT, 3, byte strobes discarded after each bitslip before comparing again (0..15).
MAX_SLIPS, 8, bitslips allowed before declaring failure (1..15).
TIMEOUT, 256, rxi_lclk cycles without byte_valid while busy before failure (2..65535).

Ports:
rxi_lclk  in  1  fast receive clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
align_start  in  1  single-cycle pulse that starts or restarts alignment
byte_valid  in  1  one-cycle strobe marking a new frame_byte (nominally every 4 rxi_lclk)
frame_byte  in  8  deserialized frame-lane byte; MSB is the earliest bit
bitslip  out  1  single-cycle pulse that requests the deserializer to shift by one bit
busy  out  1  high while alignment is in progress
aligned  out  1  lock achieved; held until align_start or reset
align_fail  out  1  alignment failed (slips exhausted or timeout); held until align_start or reset
fail_timeout  out  1  qualifies align_fail: high means the failure was caused by timeout
slip_cnt  out  4  number of bitslips issued since the last align_start

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. All outputs are registered.
- States: IDLE, SETTLE, CHECK, SLIP, WAIT, LOCKED, FAIL. busy=1 in SETTLE, CHECK, SLIP and WAIT.
- align_start, from any state: next state SETTLE. Clears aligned, align_fail, fail_timeout, slip_cnt, the match count and the timeout count. bitslip is 0 in that cycle. align_start has priority over a byte_valid in the same cycle; that byte is ignored.
- SETTLE: counts byte_valid strobes. After SETTLE_BYTES strobes, go to CHECK. If SETTLE_BYTES=0, enter CHECK directly.
- CHECK: evaluates only on byte_valid.
  - frame_byte==TRAIN_PATTERN: increment the match count. On the MATCH_CNT-th consecutive match, go to LOCKED; aligned=1 in the cycle after that strobe.
  - Mismatch, slip_cnt<MAX_SLIPS: clear the match count, go to SLIP.
  - Mismatch, slip_cnt==MAX_SLIPS: go to FAIL.
- SLIP: lasts exactly one cycle.
  - bitslip=1, registered, so it appears in the cycle after the mismatching strobe.
  - slip_cnt increments, saturating at 15. Next state WAIT.
- WAIT: discards SLIP_WAIT strobes, then goes to CHECK. A byte_valid in the SLIP cycle is not counted.
- Timeout:
  - A 16-bit counter clears on every byte_valid and on state entry, and increments each cycle in SETTLE, CHECK and WAIT.
  - When it reaches TIMEOUT, go to FAIL with fail_timeout=1.
- LOCKED: aligned=1, busy=0. frame_byte is ignored. No bitslip until the next align_start.
- FAIL: align_fail=1, busy=0. fail_timeout=0 for exhausted slips; fail_timeout=1 for timeout.
- IDLE: no action. byte_valid is ignored.
- Consecutive bitslip pulses are separated by at least SLIP_WAIT+1 byte strobes.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). The first align_start after deassertion starts normally.

Test Plan:
- Reset check: hold reset, then release with no stimulus → all outputs 0 for 50 cycles; a byte_valid in IDLE leaves all outputs 0.
- Already aligned: align_start, then 0xF0 on byte_valid every 4 cycles → after 2 settle bytes and 4 matches, aligned=1 in the cycle after the 6th strobe; bitslip never asserted; slip_cnt=0; busy=0.
- Rotated input: bench rotates frame_byte by one bit per bitslip, starting with 3 rotations needed (0x1E) → exactly 3 single-cycle bitslip pulses, each ≥4 strobes apart; then aligned=1, slip_cnt=3.
- Slips exhausted: constant 0x00 → 8 bitslip pulses, then align_fail=1, fail_timeout=0, slip_cnt=8, busy=0.
- Timeout: align_start, then no byte_valid → align_fail=1 and fail_timeout=1 after 256 cycles; no bitslip.
- Restart and reset:
  - align_start during WAIT with slip_cnt=2 → slip_cnt=0 and state SETTLE; no bitslip in that cycle.
  - align_start coincident with byte_valid → that byte is ignored.
  - reset asserted during CHECK → all outputs 0 immediately.
